// File: rtl/chacha_keystream_gen_if.sv
// Bundle of the control, key material and keystream handshake signals
// between the key/nonce registers, the keystream generator and the XOR datapath.
interface chacha_keystream_gen_if #(
  parameter int NUM_BLOCKS_W = 16
);
  logic                    i_start;
  logic                    i_abort;
  logic [255:0]            i_key;
  logic [95:0]             i_nonce;
  logic [31:0]             i_counter;
  logic [NUM_BLOCKS_W-1:0] i_num_blocks;
  logic                    o_busy;
  logic [511:0]            o_keystream;
  logic                    o_keystream_valid;
  logic                    i_keystream_ready;
  logic [31:0]             o_block_counter;
  logic                    o_done;
  logic                    o_ctr_wrap;

  modport master (
    output i_start, i_abort, i_key, i_nonce, i_counter, i_num_blocks, i_keystream_ready,
    input  o_busy, o_keystream, o_keystream_valid, o_block_counter, o_done, o_ctr_wrap
  );

  modport slave (
    input  i_start, i_abort, i_key, i_nonce, i_counter, i_num_blocks, i_keystream_ready,
    output o_busy, o_keystream, o_keystream_valid, o_block_counter, o_done, o_ctr_wrap
  );
endinterface

// File: rtl/chacha_keystream_gen.sv
// ChaCha keystream generator: bursts of 512-bit blocks from one latched key/nonce/counter,
// with configurable double-round count and quarter-round units per cycle.
module chacha_keystream_gen #(
  parameter int DOUBLE_ROUNDS = 10,
  parameter int QR_PER_CYCLE  = 4,
  parameter int NUM_BLOCKS_W  = 16
) (
  input  logic                  i_aclk,
  input  logic                  i_aresetn,
  chacha_keystream_gen_if.slave ks_if
);

  localparam int STEPS_PER_DR = 8 / QR_PER_CYCLE;
  localparam int NUM_STEPS    = DOUBLE_ROUNDS * STEPS_PER_DR;
  localparam int STEP_W       = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  typedef logic [15:0][31:0] mat_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ROUND  = 3'd2,
    ST_FINAL  = 3'd3,
    ST_OUTPUT = 3'd4
  } state_t;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] quarter_round(input logic [31:0] a, input logic [31:0] b,
                                                 input logic [31:0] c, input logic [31:0] d);
    a = a + b; d = rotl32(d ^ a, 16);
    c = c + d; b = rotl32(b ^ c, 12);
    a = a + b; d = rotl32(d ^ a, 8);
    c = c + d; b = rotl32(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  // Groups 0..3 are the columns, 4..7 the diagonals (row r shifted by r).
  function automatic mat_t apply_group(input mat_t s, input logic [2:0] grp);
    logic [1:0]   j;
    logic [3:0]   ia, ib, ic, id;
    logic [127:0] q;
    mat_t         r;
    j  = grp[1:0];
    ia = {2'b00, j};
    ib = {2'b01, grp[2] ? j + 2'd1 : j};
    ic = {2'b10, grp[2] ? j + 2'd2 : j};
    id = {2'b11, grp[2] ? j + 2'd3 : j};
    q  = quarter_round(s[ia], s[ib], s[ic], s[id]);
    r  = s;
    r[ia] = q[127:96];
    r[ib] = q[95:64];
    r[ic] = q[63:32];
    r[id] = q[31:0];
    return r;
  endfunction

  state_t                  state_r, state_nxt_s;
  logic [255:0]            key_r;
  logic [95:0]             nonce_r;
  logic [31:0]             ctr_r;
  logic [NUM_BLOCKS_W-1:0] remain_r;
  mat_t                    work_r, saved_r, ks_r;
  logic [STEP_W-1:0]       step_r;
  logic                    valid_r, done_r, wrap_r, busy_r;

  logic                    accept_s, hs_s, last_blk_s;
  logic [2:0]              group_base_s;
  mat_t                    load_s, round_s, final_s;

  assign accept_s   = (state_r == ST_IDLE) && ks_if.i_start && !ks_if.i_abort &&
                      (ks_if.i_num_blocks != {NUM_BLOCKS_W{1'b0}});
  assign hs_s       = valid_r && ks_if.i_keystream_ready;
  assign last_blk_s = (remain_r == NUM_BLOCKS_W'(1));

  // Initial matrix: constants, key, block counter, nonce
  always_comb begin
    load_s = {nonce_r, ctr_r, key_r,
              32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
  end

  // One step: QR_PER_CYCLE disjoint quarter rounds taken in column-then-diagonal order
  always_comb begin
    group_base_s = 3'((int'(step_r) % STEPS_PER_DR) * QR_PER_CYCLE);
    round_s      = work_r;
    for (int u = 0; u < QR_PER_CYCLE; u++) begin
      round_s = apply_group(round_s, group_base_s + 3'(u));
    end
  end

  // Feed-forward add of the saved input matrix
  always_comb begin
    final_s = work_r;
    for (int k = 0; k < 16; k++) begin
      final_s[k] = work_r[k] + saved_r[k];
    end
  end

  // Next-state logic; abort overrides every other event
  always_comb begin
    state_nxt_s = state_r;
    if (ks_if.i_abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_nxt_s = ST_LOAD;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_LOAD:  state_nxt_s = ST_ROUND;
        ST_ROUND: begin
          if (step_r == LAST_STEP) begin
            state_nxt_s = ST_FINAL;
          end else begin
            state_nxt_s = ST_ROUND;
          end
        end
        ST_FINAL: state_nxt_s = ST_OUTPUT;
        ST_OUTPUT: begin
          if (!hs_s) begin
            state_nxt_s = ST_OUTPUT;
          end else if (last_blk_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Burst parameters: latched on accept, advanced on each accepted block
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      key_r    <= 256'd0;
      nonce_r  <= 96'd0;
      ctr_r    <= 32'd0;
      remain_r <= {NUM_BLOCKS_W{1'b0}};
    end else if (accept_s) begin
      key_r    <= ks_if.i_key;
      nonce_r  <= ks_if.i_nonce;
      ctr_r    <= ks_if.i_counter;
      remain_r <= ks_if.i_num_blocks;
    end else if (hs_s) begin
      ctr_r    <= ctr_r + 32'd1;
      remain_r <= remain_r - NUM_BLOCKS_W'(1);
    end
  end

  // Working/saved matrices and round step counter
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      work_r  <= '{default: 32'd0};
      saved_r <= '{default: 32'd0};
      step_r  <= {STEP_W{1'b0}};
    end else begin
      case (state_r)
        ST_LOAD: begin
          work_r  <= load_s;
          saved_r <= load_s;
          step_r  <= {STEP_W{1'b0}};
        end
        ST_ROUND: begin
          work_r <= round_s;
          step_r <= step_r + STEP_W'(1);
        end
        default: begin
          work_r <= work_r;
        end
      endcase
    end
  end

  // Output registers; a handshake coinciding with abort still completes
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      ks_r    <= '{default: 32'd0};
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      wrap_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
      done_r <= hs_s && last_blk_s && !ks_if.i_abort;
      wrap_r <= hs_s && (ctr_r == 32'hFFFF_FFFF);
      if (ks_if.i_abort) begin
        valid_r <= 1'b0;
      end else if (state_r == ST_FINAL) begin
        valid_r <= 1'b1;
        ks_r    <= final_s;
      end else if (hs_s) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign ks_if.o_busy            = busy_r;
  assign ks_if.o_keystream       = ks_r;
  assign ks_if.o_keystream_valid = valid_r;
  assign ks_if.o_block_counter   = ctr_r;
  assign ks_if.o_done            = done_r;
  assign ks_if.o_ctr_wrap        = wrap_r;

endmodule

// File: tb/tb_chacha_keystream_gen.sv
// Bench for chacha_keystream_gen: RFC-style block model, per-cycle scoreboard on the
// QR_PER_CYCLE=4 instance, directed latency/value checks on the 4/2/1 instances.
module tb_chacha_keystream_gen;
  localparam int NBW = 16;
  localparam int DR  = 10;

  typedef struct {
    logic [511:0] ks;
    logic [31:0]  ctr;
    bit           last;
  } exp_t;

  logic clk, rst_n;
  logic start, abort, ready;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  ctr;
  logic [NBW-1:0] nblk;
  int n_checks = 0, n_fail = 0, done_cnt = 0, wrap_cnt = 0;
  bit exp_done = 1'b0, exp_wrap = 1'b0;
  exp_t sbq[$];

  localparam logic [511:0] RFC_BLOCK = {
    32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
    32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
    32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
    32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};

  chacha_keystream_gen_if #(.NUM_BLOCKS_W(NBW)) if4 ();
  chacha_keystream_gen_if #(.NUM_BLOCKS_W(NBW)) if2 ();
  chacha_keystream_gen_if #(.NUM_BLOCKS_W(NBW)) if1 ();

  assign {if4.i_start, if4.i_abort, if4.i_key, if4.i_nonce, if4.i_counter, if4.i_num_blocks, if4.i_keystream_ready} = {start, abort, key, nonce, ctr, nblk, ready};
  assign {if2.i_start, if2.i_abort, if2.i_key, if2.i_nonce, if2.i_counter, if2.i_num_blocks, if2.i_keystream_ready} = {start, abort, key, nonce, ctr, nblk, 1'b1};
  assign {if1.i_start, if1.i_abort, if1.i_key, if1.i_nonce, if1.i_counter, if1.i_num_blocks, if1.i_keystream_ready} = {start, abort, key, nonce, ctr, nblk, 1'b1};

  chacha_keystream_gen #(.DOUBLE_ROUNDS(DR), .QR_PER_CYCLE(4), .NUM_BLOCKS_W(NBW)) dut4 (.i_aclk(clk), .i_aresetn(rst_n), .ks_if(if4.slave));
  chacha_keystream_gen #(.DOUBLE_ROUNDS(DR), .QR_PER_CYCLE(2), .NUM_BLOCKS_W(NBW)) dut2 (.i_aclk(clk), .i_aresetn(rst_n), .ks_if(if2.slave));
  chacha_keystream_gen #(.DOUBLE_ROUNDS(DR), .QR_PER_CYCLE(1), .NUM_BLOCKS_W(NBW)) dut1 (.i_aclk(clk), .i_aresetn(rst_n), .ks_if(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] qr128(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    a = a + b; d = rl(d ^ a, 16);
    c = c + d; b = rl(b ^ c, 12);
    a = a + b; d = rl(d ^ a, 8);
    c = c + d; b = rl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  // Reference ChaCha block function written straight from the algorithm description
  function automatic logic [511:0] model_block(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    logic [31:0] s [16];
    logic [31:0] x [16];
    logic [127:0] q;
    int g [8][4];
    logic [511:0] r;
    g = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
          '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int j = 0; j < 8; j++) s[4 + j] = k[32 * j +: 32];
    s[12] = c;
    for (int j = 0; j < 3; j++) s[13 + j] = n[32 * j +: 32];
    x = s;
    for (int rnd = 0; rnd < DR; rnd++) begin
      for (int q8 = 0; q8 < 8; q8++) begin
        q = qr128(x[g[q8][0]], x[g[q8][1]], x[g[q8][2]], x[g[q8][3]]);
        x[g[q8][0]] = q[127:96]; x[g[q8][1]] = q[95:64];
        x[g[q8][2]] = q[63:32];  x[g[q8][3]] = q[31:0];
      end
    end
    for (int w = 0; w < 16; w++) r[32 * w +: 32] = x[w] + s[w];
    return r;
  endfunction

  function automatic logic dut_valid(input int w);
    case (w)
      4: return if4.o_keystream_valid;
      2: return if2.o_keystream_valid;
      default: return if1.o_keystream_valid;
    endcase
  endfunction

  function automatic logic [511:0] dut_ks(input int w);
    case (w)
      4: return if4.o_keystream;
      2: return if2.o_keystream;
      default: return if1.o_keystream;
    endcase
  endfunction

  // Scoreboard: every cycle, the main instance's outputs against the expected queue
  always @(negedge clk) begin
    if (rst_n) begin
      chk("done_pulse", {511'd0, if4.o_done}, {511'd0, exp_done});
      chk("wrap_pulse", {511'd0, if4.o_ctr_wrap}, {511'd0, exp_wrap});
      if (if4.o_done) done_cnt++;
      if (if4.o_ctr_wrap) wrap_cnt++;
      exp_done = 1'b0;
      exp_wrap = 1'b0;
      if (if4.o_keystream_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_valid", {511'd0, if4.o_keystream_valid}, 512'd0);
        end else begin
          chk("keystream", if4.o_keystream, sbq[0].ks);
          chk("block_counter", {480'd0, if4.o_block_counter}, {480'd0, sbq[0].ctr});
          if (ready) begin
            exp_done = sbq[0].last && !abort;
            exp_wrap = (sbq[0].ctr == 32'hFFFF_FFFF);
            void'(sbq.pop_front());
          end
        end
      end
      if (abort) sbq.delete();
    end
  end

  task automatic issue(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c, input int nb);
    exp_t e;
    for (int b = 0; b < nb; b++) begin
      e.ks = model_block(k, n, c + 32'(b));
      e.ctr = c + 32'(b);
      e.last = (b == nb - 1);
      sbq.push_back(e);
    end
    key = k; nonce = n; ctr = c; nblk = NBW'(nb); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int i = 0;
    while (i < 3000 && (if4.o_busy || if2.o_busy || if1.o_busy)) begin
      @(posedge clk); #1; i++;
    end
    chk(nm, {509'd0, if4.o_busy, if2.o_busy, if1.o_busy}, 512'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic measure(input int w, input int exp_lat, input logic [511:0] exp_ks, input logic [63:0] w01);
    int lat = 0;
    logic [511:0] got;
    for (int c = 1; c <= 200 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (dut_valid(w)) lat = c;
    end
    got = dut_ks(w);
    chk($sformatf("latency_qr%0d", w), 512'(lat), 512'(exp_lat));
    chk($sformatf("block_qr%0d", w), got, exp_ks);
    chk($sformatf("word01_qr%0d", w), {448'd0, got[63:0]}, {448'd0, w01});
  endtask

  task automatic single_all(input string nm, input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                            input logic [63:0] w01);
    logic [511:0] m;
    int d0;
    m = model_block(k, n, c);
    chk({nm, "_model_w01"}, {448'd0, m[63:0]}, {448'd0, w01});
    d0 = done_cnt;
    issue(k, n, c, 1);
    fork
      measure(4, 22, m, w01);
      measure(2, 42, m, w01);
      measure(1, 82, m, w01);
    join
    wait_idle({nm, "_idle"});
    chk({nm, "_done_once"}, 512'(done_cnt - d0), 512'd1);
  endtask

  initial begin
    logic [255:0] rfc_key, k3;
    logic [511:0] m;
    int d0, w0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
    key = 256'd0; nonce = 96'd0; ctr = 32'd0; nblk = NBW'(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {if4.o_keystream, if4.o_block_counter, if4.o_busy, if4.o_keystream_valid, if4.o_done, if4.o_ctr_wrap}, 548'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All-zero key/nonce/counter, ready high
    ready = 1'b1;
    single_all("zero", 256'd0, 96'd0, 32'd0, 64'h903df1a0_ade0b876);

    // RFC test vector, with the whole model block pinned to the published output
    for (int j = 0; j < 8; j++) rfc_key[32 * j +: 32] = {8'(4 * j + 3), 8'(4 * j + 2), 8'(4 * j + 1), 8'(4 * j)};
    m = model_block(rfc_key, {32'h0, 32'h4a000000, 32'h09000000}, 32'd1);
    chk("rfc_model_block", m, RFC_BLOCK);
    single_all("rfc", rfc_key, {32'h0, 32'h4a000000, 32'h09000000}, 32'd1, 64'h15593bd1_e4e7f110);

    // Zero-length burst is ignored
    nblk = NBW'(0); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("zero_blocks_ignored", {511'd0, if4.o_busy}, 512'd0);

    // Three-block burst with random ready, input churn and a stray start mid-burst
    for (int j = 0; j < 8; j++) k3[32 * j +: 32] = $urandom();
    d0 = done_cnt;
    ready = 1'b0;
    issue(k3, 96'h0123_4567_89ab_cdef_0f1e_2d3c, 32'h0000_1000, 3);
    key = ~k3; ctr = 32'hdead_beef; nonce = 96'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3000 && if4.o_busy; i++) begin
      ready = ($urandom_range(0, 2) == 0);
      @(posedge clk); #1;
    end
    ready = 1'b1;
    wait_idle("burst_idle");
    chk("burst_done_once", 512'(done_cnt - d0), 512'd1);
    chk("burst_queue_drained", 512'(sbq.size()), 512'd0);

    // Counter wrap across a two-block burst
    d0 = done_cnt; w0 = wrap_cnt;
    issue(k3, 96'd7, 32'hFFFF_FFFF, 2);
    wait_idle("wrap_idle");
    chk("wrap_once", 512'(wrap_cnt - w0), 512'd1);
    chk("wrap_done_once", 512'(done_cnt - d0), 512'd1);

    // Abort while rounds are running
    d0 = done_cnt;
    issue(rfc_key, 96'd9, 32'd100, 2);
    repeat (8) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_round_idle", {510'd0, if4.o_busy, if4.o_keystream_valid}, 512'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_round_no_done", 512'(done_cnt - d0), 512'd0);
    wait_idle("abort_round_settle");
    d0 = done_cnt;
    issue(rfc_key, {32'h0, 32'h4a000000, 32'h09000000}, 32'd1, 1);
    wait_idle("after_abort1_idle");
    chk("after_abort1_done", 512'(done_cnt - d0), 512'd1);

    // Abort while a finished block is stalled
    ready = 1'b0;
    d0 = done_cnt;
    issue(k3, 96'd3, 32'd42, 1);
    for (int i = 0; i < 100 && !if4.o_keystream_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("stall_valid_seen", {511'd0, if4.o_keystream_valid}, {511'd0, 1'b1});
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_stall_idle", {510'd0, if4.o_busy, if4.o_keystream_valid}, 512'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_stall_no_done", 512'(done_cnt - d0), 512'd0);
    ready = 1'b1;
    wait_idle("abort_stall_settle");
    d0 = done_cnt;
    issue(256'd0, 96'd0, 32'd0, 1);
    wait_idle("after_abort2_idle");
    chk("after_abort2_done", 512'(done_cnt - d0), 512'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

endmodule
